// File: rtl/sccb_config_seq_if.sv
// Bundle between the SCCB configuration sequencer and its table ROM / camera pins / status consumer.
// The slave modport is the sequencer side; the master modport is the host/ROM side.
interface sccb_config_seq_if;
    logic        start_in;
    logic [7:0]  rom_index_out;
    logic [15:0] rom_data_in;
    logic        sioc_out;
    logic        siod_out;
    logic        busy_out;
    logic        done_out;
    logic [7:0]  writes_out;

    modport slave (
        input  start_in, rom_data_in,
        output rom_index_out, sioc_out, siod_out, busy_out, done_out, writes_out
    );

    modport master (
        output start_in, rom_data_in,
        input  rom_index_out, sioc_out, siod_out, busy_out, done_out, writes_out
    );
endinterface

// File: rtl/sccb_config_seq.sv
// Walks a register table and issues one 3-phase SCCB write (ID 0x42, reg, data) per entry,
// with support for timed delay entries and an end marker.
module sccb_config_seq #(
    parameter int unsigned CLK_DIV      = 163,
    parameter int unsigned GAP_TICKS    = 8,
    parameter int unsigned DELAY_CYCLES = 650000
) (
    input  logic             clk_in,
    input  logic             rst_in,
    sccb_config_seq_if.slave bus
);
    localparam int unsigned CNT_MAX    = (CLK_DIV > DELAY_CYCLES) ? CLK_DIV : DELAY_CYCLES;
    localparam int unsigned CNT_W      = $clog2(CNT_MAX + 1);
    localparam int unsigned TK_W       = 8;
    localparam int unsigned START_LAST = 1;
    localparam int unsigned BITS_LAST  = 107;
    localparam int unsigned STOP_LAST  = 2;
    localparam logic [7:0]  DEV_ID     = 8'h42;
    localparam logic [15:0] ENT_END    = 16'hFFFF;
    localparam logic [15:0] ENT_DELAY  = 16'hFFF0;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_START, S_BITS, S_STOP, S_GAP, S_DELAY, S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [TK_W-1:0]   tk_q, tk_d;
    logic [7:0]        idx_q, idx_d;
    logic [15:0]       entry_q, entry_d;
    logic [7:0]        writes_q, writes_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              sioc_q, sioc_d;
    logic              siod_q, siod_d;
    logic              tick;
    logic              advance;
    logic [4:0]        slot;
    logic [26:0]       frame;

    // One shared down-counter: tick divider, FETCH wait and DELAY length.
    assign tick  = (cnt_q == '0);
    assign slot  = tk_q[6:2];
    // Each byte is followed by a released (high) acknowledge slot.
    assign frame = {DEV_ID, 1'b1, entry_q[15:8], 1'b1, entry_q[7:0], 1'b1};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        tk_d     = tk_q;
        idx_d    = idx_q;
        entry_d  = entry_q;
        writes_d = writes_q;
        busy_d   = busy_q;
        done_d   = done_q;
        sioc_d   = 1'b1;
        siod_d   = 1'b1;
        advance  = 1'b0;

        if (state_q inside {S_START, S_BITS, S_STOP, S_GAP}) begin
            cnt_d = tick ? CNT_W'(CLK_DIV - 1) : cnt_q - CNT_W'(1);
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start_in) begin
                    idx_d    = '0;
                    writes_d = '0;
                    done_d   = 1'b0;
                    busy_d   = 1'b1;
                    cnt_d    = CNT_W'(1);
                    state_d  = S_FETCH;
                end
            end
            S_FETCH: begin
                if (tick) begin
                    entry_d = bus.rom_data_in;
                    state_d = S_DECODE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DECODE: begin
                if (entry_q == ENT_END) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else if (entry_q == ENT_DELAY) begin
                    state_d = S_DELAY;
                    cnt_d   = CNT_W'(DELAY_CYCLES - 1);
                end else begin
                    state_d = S_START;
                    cnt_d   = CNT_W'(CLK_DIV - 1);
                    tk_d    = '0;
                end
            end
            S_START: begin
                siod_d = (tk_q == '0);
                if (tick) begin
                    if (tk_q == TK_W'(START_LAST)) begin
                        state_d = S_BITS;
                        tk_d    = '0;
                    end else begin
                        tk_d = tk_q + TK_W'(1);
                    end
                end
            end
            S_BITS: begin
                // SIOC low for the first half of the slot, high for the second half.
                sioc_d = tk_q[1];
                siod_d = frame[5'd26 - slot];
                if (tick) begin
                    if (tk_q == TK_W'(BITS_LAST)) begin
                        state_d = S_STOP;
                        tk_d    = '0;
                    end else begin
                        tk_d = tk_q + TK_W'(1);
                    end
                end
            end
            S_STOP: begin
                sioc_d = (tk_q != '0);
                siod_d = (tk_q == TK_W'(STOP_LAST));
                if (tick) begin
                    if (tk_q == TK_W'(STOP_LAST)) begin
                        state_d = S_GAP;
                        tk_d    = '0;
                        if (writes_q != 8'hFF) begin
                            writes_d = writes_q + 8'd1;
                        end
                    end else begin
                        tk_d = tk_q + TK_W'(1);
                    end
                end
            end
            S_GAP: begin
                if (tick) begin
                    if (tk_q == TK_W'(GAP_TICKS - 1)) begin
                        advance = 1'b1;
                    end else begin
                        tk_d = tk_q + TK_W'(1);
                    end
                end
            end
            S_DELAY: begin
                if (tick) begin
                    advance = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Index 255 never wraps: the walk ends there.
        if (advance) begin
            if (idx_q == 8'hFF) begin
                state_d = S_DONE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end else begin
                idx_d   = idx_q + 8'd1;
                cnt_d   = CNT_W'(1);
                state_d = S_FETCH;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            tk_q     <= '0;
            idx_q    <= '0;
            entry_q  <= '0;
            writes_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            sioc_q   <= 1'b1;
            siod_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            tk_q     <= tk_d;
            idx_q    <= idx_d;
            entry_q  <= entry_d;
            writes_q <= writes_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            sioc_q   <= sioc_d;
            siod_q   <= siod_d;
        end
    end

    assign bus.rom_index_out = idx_q;
    assign bus.sioc_out      = sioc_q;
    assign bus.siod_out      = siod_q;
    assign bus.busy_out      = busy_q;
    assign bus.done_out      = done_q;
    assign bus.writes_out    = writes_q;
endmodule

// File: tb/tb_sccb_config_seq.sv
// Bench for sccb_config_seq: directed table walks, with an SCCB bus monitor that decodes
// each write and checks it against a queue of expected {id, reg, data} triples.
module tb_sccb_config_seq;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sccb_config_seq_if bus ();

    sccb_config_seq #(
        .CLK_DIV      (2),
        .GAP_TICKS    (8),
        .DELAY_CYCLES (100)
    ) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus)
    );

    logic [15:0] rom [256];
    assign bus.rom_data_in = rom[bus.rom_index_out];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [23:0] exp_q [$];

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    // Bus monitor: start = SIOD falls with SIOC high, stop = SIOD rises with SIOC high.
    logic        prev_sioc = 1'b1;
    logic        prev_siod = 1'b1;
    logic        in_frame  = 1'b0;
    int          nbits     = 0;
    int          sioc_edges = 0;
    int          start_cyc = 0;
    logic [27:0] shreg     = '0;

    always @(negedge clk) begin
        logic [23:0] e;
        if (rst) begin
            in_frame = 1'b0;
            nbits    = 0;
        end else begin
            if (bus.sioc_out != prev_sioc) sioc_edges++;
            if (prev_sioc && bus.sioc_out && prev_siod && !bus.siod_out) begin
                in_frame  = 1'b1;
                nbits     = 0;
                shreg     = '0;
                start_cyc = cyc;
            end else if (prev_sioc && bus.sioc_out && !prev_siod && bus.siod_out && in_frame) begin
                in_frame = 1'b0;
                // 27 data/ack slots plus the SIOC rise inside the stop condition.
                check("bit_count", 32'(nbits), 32'd28);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got 0x%0h with no write expected",
                             {shreg[27:20], shreg[18:11], shreg[9:2]});
                end else begin
                    e = exp_q.pop_front();
                    check("write_bytes", 32'({shreg[27:20], shreg[18:11], shreg[9:2]}), 32'(e));
                    check("ack_slots", 32'({shreg[19], shreg[10], shreg[1], shreg[0]}), 32'b1110);
                end
            end
            if (!prev_sioc && bus.sioc_out && in_frame) begin
                shreg = {shreg[26:0], bus.siod_out};
                nbits++;
            end
        end
        prev_sioc = bus.sioc_out;
        prev_siod = bus.siod_out;
    end

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = 16'hFFFF;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 bus.start_in = 1'b1;
        @(posedge clk); #1 bus.start_in = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc, input string nm);
        int n = 0;
        while (!bus.done_out && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        #1;
        check(nm, 32'(bus.done_out), 32'd1);
    endtask

    initial begin
        int e0;
        int n;
        int drop_cyc;
        rst = 1'b1;
        bus.start_in = 1'b0;
        clear_rom();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_sioc", 32'(bus.sioc_out), 32'd1);
        check("rst_siod", 32'(bus.siod_out), 32'd1);
        check("rst_busy", 32'(bus.busy_out), 32'd0);
        check("rst_done", 32'(bus.done_out), 32'd0);
        check("rst_writes", 32'(bus.writes_out), 32'd0);
        check("rst_index", 32'(bus.rom_index_out), 32'd0);
        rst = 1'b0;

        // Single write; busy falls 242 cycles after the start-condition SIOD fall
        clear_rom();
        rom[0] = 16'h1280;
        exp_q.push_back(24'h421280);
        pulse_start();
        check("start_busy", 32'(bus.busy_out), 32'd1);
        n = 0;
        while (bus.busy_out && n < 600) begin
            @(negedge clk);
            n++;
        end
        drop_cyc = cyc;
        checks++;
        if (drop_cyc - start_cyc < 238 || drop_cyc - start_cyc > 246) begin
            errors++;
            $display("FAIL busy_drop_latency: got %0d cycles expected 242 +/-4", drop_cyc - start_cyc);
        end
        #1;
        check("single_done", 32'(bus.done_out), 32'd1);
        check("single_writes", 32'(bus.writes_out), 32'd1);

        // Delay entry, then one write
        clear_rom();
        rom[0] = 16'hFFF0;
        rom[1] = 16'h1100;
        exp_q.push_back(24'h421100);
        e0 = sioc_edges;
        pulse_start();
        repeat (100) @(negedge clk);
        #1;
        check("delay_quiet", 32'(sioc_edges - e0), 32'd0);
        wait_done(800, "delay_done");
        check("delay_writes", 32'(bus.writes_out), 32'd1);

        // Empty table
        clear_rom();
        e0 = sioc_edges;
        pulse_start();
        wait_done(4, "empty_done");
        check("empty_edges", 32'(sioc_edges - e0), 32'd0);
        check("empty_writes", 32'(bus.writes_out), 32'd0);

        // start_in during a walk is ignored
        clear_rom();
        rom[0] = 16'h1101;
        rom[1] = 16'h2202;
        rom[2] = 16'h3303;
        exp_q.push_back(24'h421101);
        exp_q.push_back(24'h422202);
        exp_q.push_back(24'h423303);
        pulse_start();
        repeat (100) @(posedge clk);
        pulse_start();
        check("ignored_start_busy", 32'(bus.busy_out), 32'd1);
        check("ignored_start_writes", 32'(bus.writes_out), 32'd0);
        wait_done(2000, "three_done");
        check("three_writes", 32'(bus.writes_out), 32'd3);
        check("three_drained", 32'(exp_q.size()), 32'd0);

        // Restart after done clears status
        clear_rom();
        rom[0] = 16'h1505;
        exp_q.push_back(24'h421505);
        pulse_start();
        check("restart_done", 32'(bus.done_out), 32'd0);
        check("restart_writes", 32'(bus.writes_out), 32'd0);
        check("restart_index", 32'(bus.rom_index_out), 32'd0);
        check("restart_busy", 32'(bus.busy_out), 32'd1);
        wait_done(600, "restart_walk_done");
        check("restart_walk_writes", 32'(bus.writes_out), 32'd1);

        // Reset during the register-address byte aborts; walk then replays from index 0
        clear_rom();
        rom[0] = 16'h3A04;
        pulse_start();
        n = 0;
        while (!(in_frame && nbits == 12) && n < 400) begin
            @(negedge clk); #1;
            n++;
        end
        check("abort_reached_addr", 32'(nbits), 32'd12);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;
        check("abort_sioc", 32'(bus.sioc_out), 32'd1);
        check("abort_siod", 32'(bus.siod_out), 32'd1);
        check("abort_busy", 32'(bus.busy_out), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        exp_q.push_back(24'h423A04);
        pulse_start();
        check("replay_index", 32'(bus.rom_index_out), 32'd0);
        wait_done(600, "replay_done");
        check("replay_writes", 32'(bus.writes_out), 32'd1);

        repeat (5) @(posedge clk);
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1);
    end
endmodule
